// File: rtl/alu_if.sv
// Operand/opcode bus between the controller and the 4-bit ALU.
// The controller drives the operands, opcode and strobe. The ALU returns the registered result.
interface alu_if;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [2:0] s;
  logic       ld;
  logic [7:0] out;

  modport master (
    output in1,
    output in2,
    output s,
    output ld,
    input  out
  );

  modport slave (
    input  in1,
    input  in2,
    input  s,
    input  ld,
    output out
  );
endinterface

// File: rtl/alu.sv
// 4-bit registered ALU with an 8-bit result.
// Opcodes 101/110 reuse out[3:0] as a loadable up/down counter, with the terminal-count flag in out[4].
module alu (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_CMP  = 3'b100,
    OP_UP   = 3'b101,
    OP_DOWN = 3'b110,
    OP_MUL2 = 3'b111
  } op_t;

  logic [7:0] out_reg;
  logic [7:0] out_next;
  logic [4:0] sum_next;
  logic [4:0] inc_next;
  logic [3:0] count_next;
  logic       gt_next;
  logic       lt_next;
  logic       eq_next;
  op_t        op;

  assign op = op_t'(bus.s);

  always_comb begin
    sum_next = {1'b0, bus.in1} + {1'b0, bus.in2};
    inc_next = {1'b0, bus.in1} + 5'd1;
    gt_next  = (bus.in1 > bus.in2);
    lt_next  = (bus.in1 < bus.in2);
    eq_next  = (bus.in1 == bus.in2);
  end

  // Counter modes always advance when ld is low. All other opcodes hold when ld is low.
  always_comb begin
    out_next   = out_reg;
    count_next = out_reg[3:0];
    case (op)
      OP_ADD:  if (bus.ld) out_next = {3'b000, sum_next};
      OP_SUB:  if (bus.ld) out_next = {4'h0, bus.in1 - bus.in2};
      OP_INC:  if (bus.ld) out_next = {3'b000, inc_next};
      OP_DEC:  if (bus.ld) out_next = {4'h0, bus.in1 - 4'd1};
      OP_CMP:  if (bus.ld) out_next = {5'b00000, gt_next, lt_next, eq_next};
      OP_MUL2: if (bus.ld) out_next = {3'b000, bus.in1, 1'b0};
      OP_UP: begin
        count_next = bus.ld ? bus.in1 : out_reg[3:0] + 4'd1;
        out_next   = {3'b000, (count_next == 4'hF), count_next};
      end
      OP_DOWN: begin
        count_next = bus.ld ? bus.in1 : out_reg[3:0] - 4'd1;
        out_next   = {3'b000, (count_next == 4'h0), count_next};
      end
      default: out_next = out_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= 8'h00;
    end else begin
      out_reg <= out_next;
    end
  end

  assign bus.out = out_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed spec vectors, then random traffic.
// Each step is checked against an integer-arithmetic reference model.
module tb_alu;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   model_out;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the opcode table, using plain integer arithmetic.
  function automatic int ref_next(int cur, bit r, int op, bit ld, int a, int b);
    int c;
    if (r) return 0;
    case (op)
      0: return ld ? (a + b) : cur;
      1: return ld ? ((a - b + 16) % 16) : cur;
      2: return ld ? (a + 1) : cur;
      3: return ld ? ((a + 15) % 16) : cur;
      4: return ld ? ((a > b) ? 4 : ((a < b) ? 2 : 1)) : cur;
      5: begin
        c = ld ? a : ((cur % 16) + 1) % 16;
        return c + ((c == 15) ? 16 : 0);
      end
      6: begin
        c = ld ? a : ((cur % 16) + 15) % 16;
        return c + ((c == 0) ? 16 : 0);
      end
      default: return ld ? (a * 2) : cur;
    endcase
  endfunction

  // Apply one clock of stimulus. Check against the model, and against spec_exp when it is >= 0.
  task automatic step(input bit r, input int op, input bit ld, input int a, input int b,
                      input string tag, input int spec_exp);
    logic [7:0] exp8;
    logic [7:0] spec8;
    @(negedge clk);
    rst     = r;
    bus.s   = 3'(op);
    bus.ld  = ld;
    bus.in1 = 4'(a);
    bus.in2 = 4'(b);
    @(posedge clk);
    #1;
    model_out = ref_next(model_out, r, op, ld, a, b);
    exp8 = 8'(model_out);
    checks++;
    assert (bus.out === exp8) else begin
      errors++;
      $error("FAIL %s model: out=%h expected=%h", tag, bus.out, exp8);
    end
    if (spec_exp >= 0) begin
      spec8 = 8'(spec_exp);
      checks++;
      assert (bus.out === spec8) else begin
        errors++;
        $error("FAIL %s spec: out=%h expected=%h", tag, bus.out, spec8);
      end
    end
    $display("step %-10s rst=%0d s=%0d ld=%0d in1=%0d in2=%0d out=%h", tag, r, op, ld, a, b, bus.out);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_out = 0;
    rst       = 1'b1;
    bus.s     = 3'd0;
    bus.ld    = 1'b0;
    bus.in1   = 4'd0;
    bus.in2   = 4'd0;

    step(1, 0, 0, 2, 10, "reset", 8'h00);
    step(0, 0, 0, 2, 10, "hold", 8'h00);
    step(0, 0, 1, 2, 10, "add", 8'h0C);
    step(0, 0, 1, 14, 11, "add_c", 8'h19);
    step(0, 1, 1, 10, 9, "sub", 8'h01);
    step(0, 1, 1, 2, 13, "sub_wrap", 8'h05);
    step(0, 2, 1, 3, 0, "inc", 8'h04);
    step(0, 2, 1, 15, 0, "inc_c", 8'h10);
    step(0, 3, 1, 11, 0, "dec", 8'h0A);
    step(0, 3, 1, 0, 0, "dec_wrap", 8'h0F);
    step(0, 4, 1, 9, 2, "cmp_gt", 8'h04);
    step(0, 4, 1, 4, 4, "cmp_eq", 8'h01);
    step(0, 4, 1, 1, 7, "cmp_lt", 8'h02);
    step(0, 7, 1, 11, 0, "mul2", 8'h16);
    step(0, 7, 1, 4, 0, "mul2_b", 8'h08);
    step(0, 7, 0, 9, 0, "mul2_hold", 8'h08);

    step(0, 5, 1, 13, 0, "up_ld", 8'h0D);
    step(0, 5, 1, 13, 0, "up_ld2", 8'h0D);
    step(0, 5, 0, 13, 0, "up", 8'h0E);
    step(0, 5, 0, 13, 0, "up_tc", 8'h1F);
    step(0, 5, 0, 13, 0, "up_wrap", 8'h00);
    step(0, 5, 0, 13, 0, "up", 8'h01);
    step(0, 0, 0, 7, 7, "sw_hold", 8'h01);

    step(0, 6, 1, 2, 0, "dn_ld", 8'h02);
    step(0, 6, 0, 2, 0, "dn", 8'h01);
    step(0, 6, 0, 2, 0, "dn_tc", 8'h10);
    step(0, 6, 0, 2, 0, "dn_wrap", 8'h0F);
    step(0, 5, 0, 2, 0, "sw_up", 8'h00);
    step(0, 6, 0, 2, 0, "sw_dn", 8'h0F);
    step(0, 6, 0, 2, 0, "dn", 8'h0E);
    step(1, 6, 0, 2, 0, "rst_mid", 8'h00);
    step(0, 6, 1, 0, 0, "dn_ld0", 8'h10);
    step(0, 5, 1, 15, 0, "up_ld15", 8'h1F);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), int'($urandom_range(0, 7)),
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), "rand", -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 4-bit registered ALU with an 8-bit registered result.
- Selectable operations: add, subtract, increment, decrement, magnitude compare, loadable up/down 4-bit counter with terminal-count flag, and multiply-by-2.
- Single clock domain; a leaf datapath block driven by a controller that supplies the opcode and the load/enable strobe.

Parameters:
- None. Operand width is fixed at 4 bits; result width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- out  output 8  registered result
- in1  input  4  operand A; also the counter load value
- in2  input  4  operand B
- s    input  3  operation select
- ld   input  1  load/enable; meaning depends on s (see Behaviour)

Behaviour:
- All state updates happen on the rising edge of clk. out is a register with no combinational path from the inputs.
- Reset: if rst=1 at a rising edge, out <= 8'h00. Reset overrides ld and s. Reset mid-count clears the counter to 0.
- Arithmetic/logic ops (s = 000, 001, 010, 011, 100, 111):
  - ld=1: out <= f(in1, in2) at each edge. Latency is 1 clock.
  - ld=0: out holds its value.
- s=000 add: out <= {3'b0, in1 + in2} as a 5-bit sum with carry in bit 4. Example: 14+11 -> 8'h19.
- s=001 subtract: out <= {4'b0, (in1 - in2) mod 16}. There is no borrow flag. Example: 2-13 -> 8'h05.
- s=010 increment: out <= {3'b0, in1 + 1} with carry in bit 4. Example: 15 -> 8'h10.
- s=011 decrement: out <= {4'b0, (in1 - 1) mod 16}. Example: 0 -> 8'h0F.
- s=100 compare (unsigned): out <= {5'b0, gt, lt, eq}.
  - in1 > in2 -> 8'h04
  - in1 < in2 -> 8'h02
  - in1 == in2 -> 8'h01
- s=111 multiply by 2: out <= {3'b0, in1, 1'b0}. Example: 11 -> 8'h16.
- Counter ops (s = 101, 110): the count is held in out[3:0]; out[4] is the terminal-count flag; out[7:5] are always 0.
  - ld=1: count <= in1 at every edge while ld stays high. Flag <= (in1==15) for up-count, (in1==0) for down-count.
  - s=101, ld=0: count up. count <= count+1 mod 16; out[4] <= (new count == 15).
  - s=110, ld=0: count down. count <= count-1 mod 16; out[4] <= (new count == 0).
  - Wrap-around: up from 15 -> 0 with flag 0; down from 0 -> 15 with flag 0.
- Switching s into a counter mode with ld=0 counts from the current out[3:0].
- Switching from a counter mode to an arithmetic op with ld=0 holds out unchanged.
- Unused combinations: none; all 8 opcodes are defined.

Test Plan:
- rst=1 for one edge -> out=8'h00. Then rst=0, ld=0, s=000, in1=2, in2=10 -> out stays 8'h00.
- ld=1, s=000: 2+10 -> 8'h0C; 14+11 -> 8'h19. s=001: 10-9 -> 8'h01; 2-13 -> 8'h05.
- s=010: 3 -> 8'h04; 15 -> 8'h10. s=011: 11 -> 8'h0A; 0 -> 8'h0F.
- s=100: (9,2) -> 8'h04; (4,4) -> 8'h01; (1,7) -> 8'h02. s=111: 11 -> 8'h16; 4 -> 8'h08.
- s=101 up-count:
  - ld=1, in1=13 for two edges -> 8'h0D.
  - Then ld=0, successive edges -> 8'h0E, 8'h1F, 8'h00, 8'h01.
- s=110 down-count:
  - ld=1, in1=2 -> 8'h02.
  - Then ld=0 -> 8'h01, 8'h10, 8'h0F.
  - Assert rst mid-count -> 8'h00 on the next edge.
